// File: rtl/reaction_round_ctrl_if.sv
// Signal bundle between the reaction-round controller, its ms timer and the buttons/LED.
// The controller takes the slave side; whoever drives the buttons and tick takes master.
interface reaction_round_ctrl_if #(
  parameter int RT_WIDTH = 14
);
  logic                ms_tick;
  logic                start_btn;
  logic                react_btn;
  logic                timer_rst_n;
  logic                timer_en;
  logic                led_go;
  logic                busy;
  logic                result_valid;
  logic [RT_WIDTH-1:0] reaction_ms;
  logic                false_start;
  logic                timeout;

  modport slave (
    input  ms_tick, start_btn, react_btn,
    output timer_rst_n, timer_en, led_go, busy, result_valid,
           reaction_ms, false_start, timeout
  );

  modport master (
    output ms_tick, start_btn, react_btn,
    input  timer_rst_n, timer_en, led_go, busy, result_valid,
           reaction_ms, false_start, timeout
  );
endinterface

// File: rtl/reaction_round_ctrl.sv
// Reaction-time game round controller: random wait, GO LED, then count ms ticks until the
// player reacts; reports reaction time, false start or timeout. All outputs registered.
module reaction_round_ctrl #(
  parameter int MIN_DELAY_MS = 1000,
  parameter int RANGE_MASK   = 4095,
  parameter int TIMEOUT_MS   = 9999,
  parameter int RT_WIDTH     = 14
) (
  input logic                clk,
  input logic                reset,
  reaction_round_ctrl_if.slave bus
);

  localparam int DW = $clog2(MIN_DELAY_MS + RANGE_MASK + 1);
  localparam logic [DW-1:0]       MIN_D   = DW'(MIN_DELAY_MS);
  localparam logic [15:0]         MASK16  = 16'(RANGE_MASK);
  localparam logic [RT_WIDTH-1:0] TMO_RT  = RT_WIDTH'(TIMEOUT_MS);
  localparam logic [RT_WIDTH-1:0] LAST_MS = RT_WIDTH'(TIMEOUT_MS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GO    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [15:0]         lfsr_q;
  logic [DW-1:0]       delay_cnt_q, delay_cnt_d;
  logic [RT_WIDTH-1:0] ms_cnt_q, ms_cnt_d;
  logic [RT_WIDTH-1:0] reaction_q, reaction_d;
  logic                false_start_q, false_start_d;
  logic                timeout_q, timeout_d;
  logic                start_prev_q, react_prev_q, ms_prev_q;
  logic                timer_rst_n_q, timer_en_q, led_go_q, busy_q, result_valid_q;
  logic                start_edge, react_edge, ms_edge;

  assign start_edge = bus.start_btn & ~start_prev_q;
  assign react_edge = bus.react_btn & ~react_prev_q;
  assign ms_edge    = bus.ms_tick   & ~ms_prev_q;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    delay_cnt_d   = delay_cnt_q;
    ms_cnt_d      = ms_cnt_q;
    reaction_d    = reaction_q;
    false_start_d = false_start_q;
    timeout_d     = timeout_q;
    case (state_q)
      S_IDLE: if (start_edge) state_d = S_ARM;
      S_ARM: begin
        delay_cnt_d = MIN_D + DW'(lfsr_q & MASK16);
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (react_edge) begin
          state_d       = S_FAULT;
          false_start_d = 1'b1;
        end else if (ms_edge) begin
          delay_cnt_d = delay_cnt_q - DW'(1);
          if (delay_cnt_q == DW'(1)) begin
            state_d  = S_GO;
            ms_cnt_d = '0;
          end
        end
      end
      S_GO: begin
        // A react in the same cycle as a tick wins and that tick is not counted.
        if (react_edge) begin
          state_d    = S_DONE;
          reaction_d = ms_cnt_q;
        end else if (ms_edge) begin
          ms_cnt_d = ms_cnt_q + RT_WIDTH'(1);
          if (ms_cnt_q == LAST_MS) begin
            state_d    = S_FAULT;
            timeout_d  = 1'b1;
            reaction_d = TMO_RT;
          end
        end
      end
      S_DONE, S_FAULT: if (start_edge) state_d = S_ARM;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ARM) begin
      reaction_d    = '0;
      false_start_d = 1'b0;
      timeout_d     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled only at the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      lfsr_q         <= 16'hACE1;
      delay_cnt_q    <= '0;
      ms_cnt_q       <= '0;
      reaction_q     <= '0;
      false_start_q  <= 1'b0;
      timeout_q      <= 1'b0;
      start_prev_q   <= 1'b1;
      react_prev_q   <= 1'b1;
      ms_prev_q      <= 1'b1;
      timer_rst_n_q  <= 1'b0;
      timer_en_q     <= 1'b0;
      led_go_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      delay_cnt_q    <= delay_cnt_d;
      ms_cnt_q       <= ms_cnt_d;
      reaction_q     <= reaction_d;
      false_start_q  <= false_start_d;
      timeout_q      <= timeout_d;
      start_prev_q   <= bus.start_btn;
      react_prev_q   <= bus.react_btn;
      ms_prev_q      <= bus.ms_tick;
      timer_rst_n_q  <= (state_d == S_WAIT) || (state_d == S_GO);
      timer_en_q     <= (state_d == S_WAIT) || (state_d == S_GO);
      led_go_q       <= (state_d == S_GO);
      busy_q         <= (state_d == S_ARM) || (state_d == S_WAIT) || (state_d == S_GO);
      result_valid_q <= ((state_d == S_DONE) || (state_d == S_FAULT)) && (state_d != state_q);
    end
  end

  assign bus.timer_rst_n  = timer_rst_n_q;
  assign bus.timer_en     = timer_en_q;
  assign bus.led_go       = led_go_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.reaction_ms  = reaction_q;
  assign bus.false_start  = false_start_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Bench for reaction_round_ctrl: two instances (small fixed delay / full random range)
// compared every cycle against a round-level model, plus literal checks of key moments.
module tb_reaction_round_ctrl;
  localparam int RTW = 14;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  reaction_round_ctrl_if #(.RT_WIDTH(RTW)) ia ();
  reaction_round_ctrl_if #(.RT_WIDTH(RTW)) ib ();

  reaction_round_ctrl #(.MIN_DELAY_MS(3), .RANGE_MASK(0), .TIMEOUT_MS(7), .RT_WIDTH(RTW))
    dut_a (.clk(clk), .reset(rst_a), .bus(ia.slave));
  reaction_round_ctrl #(.MIN_DELAY_MS(3), .RANGE_MASK(4095), .TIMEOUT_MS(20), .RT_WIDTH(RTW))
    dut_b (.clk(clk), .reset(rst_b), .bus(ib.slave));

  localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_GO = 3, P_END = 4;

  typedef struct {
    int          phase;
    logic [15:0] lfsr;
    int          remaining;
    int          count;
    logic        ps, pr, pm;
    logic        rv;
    int          rt;
    logic        fs, to;
  } mdl_t;

  mdl_t ma, mb;
  int   total = 0;
  int   bad   = 0;
  bit   cmp_on = 1'b0;
  bit   go_seen_a = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the game's rules given the inputs seen at that edge.
  function automatic mdl_t mstep(mdl_t m, logic rst, logic s, logic r, logic t,
                                 int min_d, int mask, int tmo);
    mdl_t n;
    logic se, re, me;
    n = m;
    if (!rst) begin
      n.phase = P_IDLE; n.lfsr = 16'hACE1; n.remaining = 0; n.count = 0;
      n.ps = 1; n.pr = 1; n.pm = 1; n.rv = 0; n.rt = 0; n.fs = 0; n.to = 0;
      return n;
    end
    se = s & ~m.ps; re = r & ~m.pr; me = t & ~m.pm;
    n.rv = 0;
    case (m.phase)
      P_IDLE: if (se) n.phase = P_ARM;
      P_ARM: begin
        n.remaining = min_d + (int'(m.lfsr) & mask);
        n.phase = P_WAIT;
      end
      P_WAIT: begin
        if (re) begin n.phase = P_END; n.fs = 1; n.rv = 1; end
        else if (me) begin
          n.remaining = m.remaining - 1;
          if (n.remaining == 0) begin n.phase = P_GO; n.count = 0; end
        end
      end
      P_GO: begin
        if (re) begin n.phase = P_END; n.rt = m.count; n.rv = 1; end
        else if (me) begin
          n.count = m.count + 1;
          if (n.count == tmo) begin n.phase = P_END; n.to = 1; n.rt = tmo; n.rv = 1; end
        end
      end
      default: if (se) n.phase = P_ARM;
    endcase
    if (n.phase == P_ARM) begin n.rt = 0; n.fs = 0; n.to = 0; end
    n.lfsr = {m.lfsr[14:0], m.lfsr[15] ^ m.lfsr[13] ^ m.lfsr[12] ^ m.lfsr[10]};
    n.ps = s; n.pr = r; n.pm = t;
    return n;
  endfunction

  function automatic logic [31:0] mexp(mdl_t m);
    logic on;
    on = (m.phase == P_WAIT) || (m.phase == P_GO);
    return {11'd0, on, on, m.phase == P_GO, (m.phase >= P_ARM) && (m.phase <= P_GO),
            m.rv, m.fs, m.to, 14'(m.rt)};
  endfunction

  function automatic logic [31:0] vec_a();
    return {11'd0, ia.timer_rst_n, ia.timer_en, ia.led_go, ia.busy, ia.result_valid,
            ia.false_start, ia.timeout, ia.reaction_ms};
  endfunction

  function automatic logic [31:0] vec_b();
    return {11'd0, ib.timer_rst_n, ib.timer_en, ib.led_go, ib.busy, ib.result_valid,
            ib.false_start, ib.timeout, ib.reaction_ms};
  endfunction

  always @(posedge clk) begin
    ma = mstep(ma, rst_a, ia.start_btn, ia.react_btn, ia.ms_tick, 3, 0, 7);
    mb = mstep(mb, rst_b, ib.start_btn, ib.react_btn, ib.ms_tick, 3, 4095, 20);
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("a_cycle", vec_a(), mexp(ma));
      check("b_cycle", vec_b(), mexp(mb));
      if (ia.led_go) go_seen_a = 1'b1;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drv(input bit b, input int w, input logic v);
    if (!b) begin
      case (w)
        0: ia.start_btn = v;
        1: ia.react_btn = v;
        default: ia.ms_tick = v;
      endcase
    end else begin
      case (w)
        0: ib.start_btn = v;
        1: ib.react_btn = v;
        default: ib.ms_tick = v;
      endcase
    end
  endtask

  task automatic pulse(input bit b, input int w, input int n = 1);
    repeat (n) begin drv(b, w, 1'b1); cyc(); drv(b, w, 1'b0); cyc(); end
  endtask

  int  delays[$];
  int  edges;
  bit  differ;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ia.start_btn = 0; ia.react_btn = 0; ia.ms_tick = 0;
    ib.start_btn = 0; ib.react_btn = 0; ib.ms_tick = 0;
    cyc();
    cmp_on = 1'b1;
    cyc(2);
    check("a_reset_state", vec_a(), 32'h0000_0000);
    rst_a = 1'b1;
    cyc(2);
    check("a_idle_state", vec_a(), 32'h0000_0000);

    // Normal round: 3 ms wait, react after 5 ms.
    pulse(0, 0);
    check("a_wait_entered", vec_a(), 32'h001A_0000);
    pulse(0, 2, 3);
    check("a_go_lit", vec_a(), 32'h001E_0000);
    pulse(0, 2, 5);
    drv(0, 1, 1'b1); cyc();
    check("a_react_result", vec_a(), 32'h0001_0005);
    drv(0, 1, 1'b0); cyc();
    check("a_result_held", vec_a(), 32'h0000_0005);

    // False start after one tick in WAIT.
    go_seen_a = 1'b0;
    pulse(0, 0);
    check("a_rearm_clears", vec_a(), 32'h001A_0000);
    pulse(0, 2);
    drv(0, 1, 1'b1); cyc();
    check("a_false_start", vec_a(), 32'h0001_8000);
    drv(0, 1, 1'b0); cyc();
    check("a_false_held", vec_a(), 32'h0000_8000);
    check("a_no_go_on_false", {31'd0, go_seen_a}, 32'd0);

    // Timeout on the 7th tick in GO.
    pulse(0, 0);
    pulse(0, 2, 3);
    pulse(0, 2, 6);
    check("a_before_timeout", vec_a(), 32'h001E_0000);
    drv(0, 2, 1'b1); cyc();
    check("a_timeout", vec_a(), 32'h0001_4007);
    drv(0, 2, 1'b0); cyc();
    check("a_timeout_held", vec_a(), 32'h0000_4007);

    // React and tick together with 4 ms counted.
    pulse(0, 0);
    pulse(0, 2, 3);
    pulse(0, 2, 4);
    drv(0, 1, 1'b1); drv(0, 2, 1'b1); cyc();
    check("a_simultaneous", vec_a(), 32'h0001_0004);
    drv(0, 1, 1'b0); drv(0, 2, 1'b0); cyc();

    // Reset during GO with start held high across it.
    pulse(0, 0);
    pulse(0, 2, 3);
    pulse(0, 2, 2);
    drv(0, 0, 1'b1); cyc();
    check("a_start_ignored_go", vec_a(), 32'h001E_0000);
    rst_a = 1'b0; cyc();
    check("a_reset_mid_round", vec_a(), 32'h0000_0000);
    cyc(2);
    rst_a = 1'b1; cyc(5);
    check("a_held_start_no_round", vec_a(), 32'h0000_0000);
    drv(0, 0, 1'b0); cyc();
    drv(0, 0, 1'b1); cyc();
    check("a_arm_after_release", vec_a(), 32'h0002_0000);
    cyc();
    check("a_wait_after_release", vec_a(), 32'h001A_0000);
    drv(0, 0, 1'b0); cyc();

    // Randomised rounds on the full-range instance.
    rst_b = 1'b1;
    for (int r = 0; r < 20; r++) begin
      cyc($urandom_range(1, 40));
      pulse(1, 0);
      if (r % 4 == 0) begin
        edges = 0;
        while (!ib.led_go && edges < 5000) begin
          pulse(1, 2);
          edges++;
        end
        check("b_go_reached", {31'd0, ib.led_go}, 32'd1);
        check("b_delay_range", {31'd0, (edges >= 3) && (edges <= 4098)}, 32'd1);
        delays.push_back(edges);
        pulse(1, 2, $urandom_range(0, 10));
        pulse(1, 1);
      end else begin
        pulse(1, 2, $urandom_range(0, 2));
        drv(1, 1, 1'b1); cyc();
        check("b_false_start", {31'd0, ib.false_start}, 32'd1);
        drv(1, 1, 1'b0); cyc();
      end
      if ($urandom_range(0, 1) == 1) pulse(1, 1);
    end
    differ = 1'b0;
    foreach (delays[i]) if (delays[i] != delays[0]) differ = 1'b1;
    check("b_delays_vary", {31'd0, differ}, 32'd1);

    cyc(2);
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
